// File: rtl/mem_wb_elastic.sv
// MEM/WB elastic pipeline register: valid/ready handshake with a two-entry
// skid buffer, synchronous flush and a wrapping retired-record counter.
module mem_wb_elastic #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter bit          HILO_EN = 1'b1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] mem_wd,
    input  logic               mem_wreg,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_hi,
    input  logic [DATA_W-1:0]  mem_lo,
    input  logic               mem_whilo,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RADDR_W-1:0] wb_wd,
    output logic               wb_wreg,
    output logic [DATA_W-1:0]  wb_wdata,
    output logic [DATA_W-1:0]  wb_hi,
    output logic [DATA_W-1:0]  wb_lo,
    output logic               wb_whilo,
    output logic [CNT_W-1:0]   retire_cnt
);

    typedef struct packed {
        logic [RADDR_W-1:0] wd;
        logic               wreg;
        logic [DATA_W-1:0]  wdata;
        logic [DATA_W-1:0]  hi;
        logic [DATA_W-1:0]  lo;
        logic               whilo;
    } rec_t;

    rec_t             in_rec;
    rec_t             main_q, main_d;
    rec_t             skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             consume;

    // Pack the incoming record; HI/LO fields are tied off when the channel is absent.
    always_comb begin
        in_rec.wd    = mem_wd;
        in_rec.wreg  = mem_wreg;
        in_rec.wdata = mem_wdata;
        in_rec.hi    = HILO_EN ? mem_hi : '0;
        in_rec.lo    = HILO_EN ? mem_lo : '0;
        in_rec.whilo = HILO_EN ? mem_whilo : 1'b0;
    end

    assign accept  = in_valid & in_ready_q & ~flush;
    assign consume = main_valid_q & out_ready;

    // Next-state for both slots, ready and counter.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;

        // A consume in a flush cycle still retires.
        if (consume) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_d.wreg  = 1'b0;
            main_d.whilo = 1'b0;
            skid_d.wreg  = 1'b0;
            skid_d.whilo = 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                // Promote skid; a same-cycle accept lands behind it in skid.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = in_rec;
                end
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = in_rec;
                end
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_d       = in_rec;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = in_rec;
                main_valid_d = 1'b1;
            end
        end

        // Ready is a register derived from skid occupancy, never from out_ready.
        in_ready_d = ~skid_valid_d;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    // Outputs come straight from the main slot; write enables are gated by valid.
    always_comb begin
        in_ready   = in_ready_q;
        out_valid  = main_valid_q;
        wb_wd      = main_q.wd;
        wb_wreg    = main_q.wreg & main_valid_q;
        wb_wdata   = main_q.wdata;
        wb_hi      = HILO_EN ? main_q.hi : '0;
        wb_lo      = HILO_EN ? main_q.lo : '0;
        wb_whilo   = HILO_EN ? (main_q.whilo & main_valid_q) : 1'b0;
        retire_cnt = cnt_q;
    end

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Self-checking bench for mem_wb_elastic: vector table, scoreboard monitor and
// hand-written reset/streaming sequences. A second instance covers HILO_EN=0, CNT_W=4.
module tb_mem_wb_elastic;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic        out_ready;

    logic        in_ready, out_valid, wb_wreg, wb_whilo;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata, wb_hi, wb_lo, retire_cnt;

    logic        in_ready2, out_valid2, wb_wreg2, wb_whilo2;
    logic [4:0]  wb_wd2;
    logic [31:0] wb_wdata2, wb_hi2, wb_lo2;
    logic [3:0]  retire_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_elastic #(.DATA_W(32), .RADDR_W(5), .HILO_EN(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
        .mem_lo(mem_lo), .mem_whilo(mem_whilo), .out_valid(out_valid), .out_ready(out_ready),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .wb_whilo(wb_whilo), .retire_cnt(retire_cnt)
    );

    mem_wb_elastic #(.DATA_W(32), .RADDR_W(5), .HILO_EN(1'b0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
        .mem_lo(mem_lo), .mem_whilo(mem_whilo), .out_valid(out_valid2), .out_ready(out_ready),
        .wb_wd(wb_wd2), .wb_wreg(wb_wreg2), .wb_wdata(wb_wdata2), .wb_hi(wb_hi2),
        .wb_lo(wb_lo2), .wb_whilo(wb_whilo2), .retire_cnt(retire_cnt2)
    );

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
    } rec_t;

    typedef struct {
        logic        vld;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic        ir;
        logic [4:0]  ewd;
        logic        ewreg;
        logic        ewhilo;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    rec_t exp_q[$];
    int   model_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic vld, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [31:0] hi, input logic [31:0] lo,
                         input logic whilo, input logic ordy, input logic fl);
        in_valid  = vld;
        mem_wd    = wd;
        mem_wreg  = wreg;
        mem_wdata = wdata;
        mem_hi    = hi;
        mem_lo    = lo;
        mem_whilo = whilo;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled mid-cycle where inputs and outputs are settled.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                model_cnt = 0;
            end else begin
                check("retire_cnt", 64'(retire_cnt), 64'(32'(model_cnt)));
                check("retire_cnt_w4", 64'(retire_cnt2), 64'(model_cnt % 16));
                check("nohilo_zero", {wb_whilo2, wb_hi2, wb_lo2} == '0 ? 64'd1 : 64'd0, 64'd1);
                if (!out_valid) begin
                    check("bubble_we", {62'd0, wb_wreg, wb_whilo}, 64'd0);
                end else if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    r = exp_q[0];
                    check("wb_wd", 64'(wb_wd), 64'(r.wd));
                    check("wb_wreg", 64'(wb_wreg), 64'(r.wreg));
                    check("wb_wdata", 64'(wb_wdata), 64'(r.wdata));
                    check("wb_hilo", {wb_hi, wb_lo}, {r.hi, r.lo});
                    check("wb_whilo", 64'(wb_whilo), 64'(r.whilo));
                    check("wb_wdata_w4", 64'(wb_wdata2), 64'(r.wdata));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
                if (out_valid && out_ready) begin
                    model_cnt++;
                end
                if (flush) begin
                    exp_q.delete();
                end else if (in_valid && in_ready) begin
                    r.wd    = mem_wd;
                    r.wreg  = mem_wreg;
                    r.wdata = mem_wdata;
                    r.hi    = mem_hi;
                    r.lo    = mem_lo;
                    r.whilo = mem_whilo;
                    exp_q.push_back(r);
                end
            end
        end
    end

    vec_t vecs[16];
    int   base;
    logic [31:0] data;

    initial begin
        // vld wd wreg wdata hi lo whilo ordy fl | ov ir ewd ewreg ewhilo ehi elo
        vecs[0]  = '{1, 1, 1, 32'h11, 1, 2, 1, 0, 0,  1, 1, 1, 1, 1, 1, 2};
        vecs[1]  = '{1, 2, 1, 32'h22, 0, 0, 0, 0, 0,  1, 0, 1, 1, 1, 1, 2};
        vecs[2]  = '{1, 3, 1, 32'h33, 0, 0, 0, 0, 0,  1, 0, 1, 1, 1, 1, 2};
        vecs[3]  = '{1, 3, 1, 32'h33, 0, 0, 0, 1, 0,  1, 1, 2, 1, 0, 0, 0};
        vecs[4]  = '{1, 3, 1, 32'h33, 0, 0, 0, 1, 0,  1, 1, 3, 1, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 32'h0,  0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0, 0};
        vecs[6]  = '{1, 4, 1, 32'h44, 0, 0, 0, 0, 0,  1, 1, 4, 1, 0, 0, 0};
        vecs[7]  = '{1, 5, 1, 32'h55, 3, 4, 1, 0, 0,  1, 0, 4, 1, 0, 0, 0};
        vecs[8]  = '{1, 6, 1, 32'h66, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{1, 7, 1, 32'h77, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 32'h0,  0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0, 0};
        vecs[11] = '{1, 8, 1, 32'h88, 1, 2, 1, 1, 0,  1, 1, 8, 1, 1, 1, 2};
        vecs[12] = '{1, 9, 0, 32'h99, 0, 0, 0, 1, 0,  1, 1, 9, 0, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 32'h0,  0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0, 0};
        vecs[14] = '{1, 10, 1, 32'hAA, 0, 0, 0, 0, 0, 1, 1, 10, 1, 0, 0, 0};
        vecs[15] = '{0, 0, 0, 32'h0,  0, 0, 0, 1, 1,  0, 1, 0, 0, 0, 0, 0};

        // Reset held with random inputs.
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_wb", {wb_wd, wb_wreg, wb_wdata, wb_whilo} == '0 ? 64'd1 : 64'd0, 64'd1);
            check("rst_hilo", {wb_hi, wb_lo}, 64'd0);
            check("rst_cnt", 64'(retire_cnt), 64'd0);
        end

        // First record accepted on the first edge after release.
        rst = 1'b1;
        drive(1, 5, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        tick();
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_wd", 64'(wb_wd), 64'd5);
        check("first_wreg", 64'(wb_wreg), 64'd1);
        check("first_wdata", 64'(wb_wdata), 64'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);

        // Vector table: back-pressure, flush and HI/LO gating.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].vld, vecs[i].wd, vecs[i].wreg, vecs[i].wdata, vecs[i].hi,
                  vecs[i].lo, vecs[i].whilo, vecs[i].ordy, vecs[i].fl);
            tick();
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].ir));
            check($sformatf("vec%0d_wreg", i), 64'(wb_wreg), 64'(vecs[i].ewreg));
            check($sformatf("vec%0d_whilo", i), 64'(wb_whilo), 64'(vecs[i].ewhilo));
            if (vecs[i].ov) begin
                check($sformatf("vec%0d_wd", i), 64'(wb_wd), 64'(vecs[i].ewd));
                check($sformatf("vec%0d_hilo", i), {wb_hi, wb_lo}, {vecs[i].ehi, vecs[i].elo});
            end
        end

        // Streaming: 100 back-to-back records with out_ready held high.
        base = model_cnt;
        for (int i = 0; i < 100; i++) begin
            data = $urandom;
            drive(1, 5'(i), 1'($urandom), data, $urandom, $urandom, 1'($urandom), 1, 0);
            tick();
            check("stream_in_ready", 64'(in_ready), 64'd1);
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_latency", 64'(wb_wdata), 64'(data));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        check("stream_drained", 64'(out_valid), 64'd0);
        check("stream_cnt", 64'(retire_cnt), 64'(32'(base + 100)));

        // Asynchronous reset mid-operation with both slots full.
        drive(1, 11, 1, 32'hB0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 12, 1, 32'hB1, 0, 0, 0, 0, 0);
        tick();
        check("full_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_cnt", 64'(retire_cnt), 64'd0);
        check("arst_cnt_w4", 64'(retire_cnt2), 64'd0);
        tick();
        rst = 1'b1;
        drive(1, 13, 1, 32'hC0, 0, 0, 0, 1, 0);
        tick();
        check("post_arst_wd", 64'(wb_wd), 64'd13);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        check("post_arst_drain", 64'(out_valid), 64'd0);
        check("post_arst_cnt", 64'(retire_cnt), 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
